// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multicycle CPU control unit: opcodes, state codes
// and the datapath select encodings.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_FETCH   = 4'd1;
    localparam state_t S_DECODE  = 4'd2;
    localparam state_t S_MEMADR  = 4'd3;
    localparam state_t S_MEMRD   = 4'd4;
    localparam state_t S_MEMWB   = 4'd5;
    localparam state_t S_MEMWR   = 4'd6;
    localparam state_t S_EXEC    = 4'd7;
    localparam state_t S_ALUWB   = 4'd8;
    localparam state_t S_BRANCH  = 4'd9;
    localparam state_t S_JUMP    = 4'd10;
    localparam state_t S_ADDI_EX = 4'd11;
    localparam state_t S_ADDI_WB = 4'd12;
    localparam state_t S_TRAP    = 4'd13;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // States whose exit always retires the current instruction (MEMWR retires
    // only once its memory access completes).
    function automatic logic is_final_state(input state_t s);
        return (s == S_MEMWB) || (s == S_ALUWB) || (s == S_BRANCH) ||
               (s == S_JUMP)  || (s == S_ADDI_WB);
    endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// Retired-instruction and free-running cycle counters for the CPU bench.
module ctrl_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_retire,
    output logic [CNT_W-1:0] o_instr_count,
    output logic [CNT_W-1:0] o_cycle_count
);

    logic [CNT_W-1:0] r_instr;
    logic [CNT_W-1:0] r_cycle;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr <= '0;
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + CNT_W'(1);
            if (i_retire) r_instr <= r_instr + CNT_W'(1);
        end
    end

    assign o_instr_count = r_instr;
    assign o_cycle_count = r_cycle;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drives all datapath selects and strobes from the state register.
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    ctrl_t  w_ctrl;
    logic   w_retire;

    // The zero flag is consumed by the datapath together with pc_write_cond.
    logic   w_unused_zero;
    assign  w_unused_zero = zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) w_next = S_MEMADR;
                else if (opcode == OPW'(OP_R))    w_next = S_EXEC;
                else if (opcode == OPW'(OP_BEQ))  w_next = S_BRANCH;
                else if (opcode == OPW'(OP_J))    w_next = S_JUMP;
                else if (opcode == OPW'(OP_ADDI)) w_next = S_ADDI_EX;
                else                              w_next = S_TRAP;
            end
            S_MEMADR:  w_next = (opcode == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            S_ADDI_EX: w_next = S_ADDI_WB;
            S_ADDI_WB: w_next = S_FETCH;
            S_TRAP:    w_next = S_TRAP;
            default:   w_next = S_IDLE;
        endcase
    end

    // IDLE decodes to all-zero, so async reset clears every output at once.
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = SRCB_IMM_SH;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRCB_B;
                w_ctrl.alu_op        = ALUOP_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: w_ctrl.reg_write = 1'b1;
            default:   w_ctrl = '0;
        endcase
    end

    assign w_retire = is_final_state(r_state) || (r_state == S_MEMWR && mem_ready);

    ctrl_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .i_clk         (clk),
        .i_rst_n       (reset),
        .i_retire      (w_retire),
        .o_instr_count (instr_count),
        .o_cycle_count (cycle_count)
    );

    assign mem_req       = w_ctrl.mem_req;
    assign mem_write     = w_ctrl.mem_write;
    assign iord          = w_ctrl.iord;
    assign ir_write      = w_ctrl.ir_write;
    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign pc_source     = w_ctrl.pc_source;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_write     = w_ctrl.reg_write;
    assign illegal_op    = r_illegal;
    assign state         = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for the multicycle control FSM: directed per-cycle vectors
// push expectations, a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;

    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                           MEMRD = 4'd4, MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7,
                           ALUWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, ADDI_EX = 4'd11,
                           ADDI_WB = 4'd12, TRAP = 4'd13;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000,
                           BAD = 6'b111111;

    typedef struct packed {
        logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       reg_dst, mem_to_reg, reg_write, illegal_op;
    } tctrl_t;

    typedef struct {
        logic [3:0]  st;
        tctrl_t      c;
        logic [31:0] ic, cc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero, mem_ready;
    logic        mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic        alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_count, cycle_count;

    exp_t        q[$];
    logic [31:0] e_ic, e_cc;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.OPW(6), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op), .state(state),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    function automatic tctrl_t exp_ctrl(input logic [3:0] s, input logic rdy);
        tctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.mem_req = 1; c.alu_src_b = 2'd1; c.ir_write = rdy; c.pc_write = rdy; end
            DECODE:  c.alu_src_b = 2'd3;
            MEMADR:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            MEMRD:   begin c.mem_req = 1; c.iord = 1; end
            MEMWB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
            MEMWR:   begin c.mem_req = 1; c.mem_write = 1; c.iord = 1; end
            EXEC:    begin c.alu_src_a = 1; c.alu_op = 2'd2; end
            ALUWB:   begin c.reg_write = 1; c.reg_dst = 1; end
            BRANCH:  begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_write_cond = 1; c.pc_source = 2'd1; end
            JUMP:    begin c.pc_write = 1; c.pc_source = 2'd2; end
            ADDI_EX: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            ADDI_WB: c.reg_write = 1;
            TRAP:    c.illegal_op = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic retires(input logic [3:0] s, input logic rdy);
        return (s == MEMWB) || (s == ALUWB) || (s == BRANCH) || (s == JUMP) ||
               (s == ADDI_WB) || (s == MEMWR && rdy);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs, queue the expected outputs for this cycle.
    task automatic step(input logic [5:0] op, input logic z, input logic rdy, input logic [3:0] st);
        exp_t e;
        opcode = op; zero = z; mem_ready = rdy;
        if (!reset) begin e_cc = 0; e_ic = 0; end
        e.st = st; e.c = exp_ctrl(st, rdy); e.ic = e_ic; e.cc = e_cc;
        q.push_back(e);
        @(posedge clk); #1;
        if (reset) begin
            e_cc = e_cc + 1;
            if (retires(st, rdy)) e_ic = e_ic + 1;
        end
    endtask

    initial begin : monitor
        exp_t   e;
        tctrl_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                      alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op};
                chk("state", {28'd0, state}, {28'd0, e.st});
                chk("ctrl",  {14'd0, a}, {14'd0, e.c});
                chk("instr_count", instr_count, e.ic);
                chk("cycle_count", cycle_count, e.cc);
            end
        end
    end

    initial begin : stim
        reset = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        e_ic = 0; e_cc = 0;
        @(posedge clk); #1;
        repeat (10) step(RT, 0, 1, IDLE);
        reset = 1'b1;
        step(RT, 0, 1, IDLE);
        // LW, zero wait states
        step(LW, 0, 1, FETCH);
        step(LW, 0, 1, DECODE);
        step(LW, 0, 1, MEMADR);
        step(LW, 0, 1, MEMRD);
        step(LW, 0, 1, MEMWB);
        // SW with three wait cycles in MEMWR
        step(SW, 0, 1, FETCH);
        step(SW, 0, 1, DECODE);
        step(SW, 0, 1, MEMADR);
        step(SW, 0, 0, MEMWR);
        step(SW, 0, 0, MEMWR);
        step(SW, 0, 0, MEMWR);
        step(SW, 0, 1, MEMWR);
        // R-type after a stalled fetch
        step(RT, 0, 0, FETCH);
        step(RT, 0, 0, FETCH);
        step(RT, 0, 1, FETCH);
        step(RT, 0, 1, DECODE);
        step(RT, 0, 1, EXEC);
        step(RT, 0, 1, ALUWB);
        // ADDI, BEQ (zero=1), J
        step(ADDI, 0, 1, FETCH);
        step(ADDI, 0, 1, DECODE);
        step(ADDI, 0, 1, ADDI_EX);
        step(ADDI, 0, 1, ADDI_WB);
        step(BEQ, 1, 1, FETCH);
        step(BEQ, 1, 1, DECODE);
        step(BEQ, 1, 1, BRANCH);
        step(JMP, 0, 1, FETCH);
        step(JMP, 0, 1, DECODE);
        step(JMP, 0, 1, JUMP);
        // Reset in the middle of a MEMRD stall
        step(LW, 0, 1, FETCH);
        step(LW, 0, 1, DECODE);
        step(LW, 0, 0, MEMADR);
        step(LW, 0, 0, MEMRD);
        step(LW, 0, 0, MEMRD);
        reset = 1'b0;
        step(LW, 0, 0, IDLE);
        reset = 1'b1;
        step(LW, 0, 1, IDLE);
        // Illegal opcode: terminal trap
        step(BAD, 0, 1, FETCH);
        step(BAD, 0, 1, DECODE);
        step(BAD, 0, 1, TRAP);
        step(RT, 0, 1, TRAP);
        step(LW, 0, 0, TRAP);
        step(RT, 0, 1, TRAP);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
